// File: rtl/weight_update_arbiter_if.sv
// Signal bundle between the weight_update_arbiter and its neighbours:
// inference control from systolic_array, the host weight-write channel,
// the shared weight_ram port of one read lane, and status/debug outputs.
// The master side drives requests, and the slave side is the arbiter.
interface weight_update_arbiter_if #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_CELLS   = 1024,
  parameter int WEIGHT_BITS = 8,
  parameter int ADDR_BITS   = $clog2(NUM_CELLS)
);
  localparam int CLASS_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  // Inference pass markers and the systolic read address
  logic                   infer_start;
  logic                   infer_done;
  logic [ADDR_BITS-1:0]   rd_addr;

  // Host update batch and write channel
  logic                   upd_begin;
  logic                   upd_end;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [CLASS_BITS-1:0]  wr_class;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [WEIGHT_BITS-1:0] wr_data;

  // Shared class-RAM port
  logic [NUM_CLASSES-1:0] ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [WEIGHT_BITS-1:0] ram_din;

  // Status and debug
  logic                   result_mixed;
  logic [15:0]            wr_count;
  logic [15:0]            wr_checksum;
  logic [1:0]             arb_state;

  modport master (
    output infer_start, infer_done, rd_addr,
    output upd_begin, upd_end, wr_valid, wr_class, wr_addr, wr_data,
    input  wr_ready, ram_we, ram_addr, ram_din,
    input  result_mixed, wr_count, wr_checksum, arb_state
  );

  modport slave (
    input  infer_start, infer_done, rd_addr,
    input  upd_begin, upd_end, wr_valid, wr_class, wr_addr, wr_data,
    output wr_ready, ram_we, ram_addr, ram_din,
    output result_mixed, wr_count, wr_checksum, arb_state
  );
endinterface

// File: rtl/weight_update_arbiter.sv
// weight_update_arbiter: shares one lane's weight_ram bank between the
// systolic inference read path and the host weight-write path.
// Inference always wins; host writes are only accepted in UPDATE, and any
// inference pass that overlaps an open update batch is flagged on
// result_mixed one cycle after infer_done.
// Optional feature macro: WEIGHT_ARB_CHECKSUM_EN builds a 16-bit wrapping
// sum of accepted write data on wr_checksum; otherwise wr_checksum is 0.
module weight_update_arbiter #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_CELLS   = 1024,
  parameter int WEIGHT_BITS = 8,
  parameter int ADDR_BITS   = $clog2(NUM_CELLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  weight_update_arbiter_if.slave   bus
);

  localparam int CLASS_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INFER     = 2'd1,
    UPDATE    = 2'd2,
    UPD_INFER = 2'd3
  } arb_state_t;

  arb_state_t             state;
  logic                   pend_begin;   // upd_begin seen during INFER
  logic                   pend_end;     // upd_end seen during UPD_INFER
  logic                   mixed;        // current pass overlaps an open batch
  logic                   result_mixed;
  logic [15:0]            wr_count;
  logic [15:0]            wr_checksum;

  logic                   wr_ready;
  logic                   accept;
  logic [NUM_CLASSES-1:0] ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [WEIGHT_BITS-1:0] ram_din;

  // A write is taken only in UPDATE and never in the cycle inference starts
  assign wr_ready = (state == UPDATE) && !bus.infer_start;
  assign accept   = bus.wr_valid && wr_ready;

  // Zero-latency RAM port mux: host write when accepted, else systolic read
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ram_we   = '0;
    ram_addr = bus.rd_addr;
    ram_din  = '0;
    if (accept) begin
      ram_addr = bus.wr_addr;
      ram_din  = bus.wr_data;
      // Out-of-range classes match no bit, so the write is dropped but counted
      for (int i = 0; i < NUM_CLASSES; i++) begin
        ram_we[i] = (bus.wr_class == CLASS_BITS'(i));
      end
    end
  end

  // Arbitration FSM with batch bookkeeping and the registered mixed flag
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every read in this block sees pre-edge values.
    if (rst) begin
      // NOTE: only control state is reset; the weight RAMs behind this block keep their contents.
      state        <= IDLE;
      pend_begin   <= 1'b0;
      pend_end     <= 1'b0;
      mixed        <= 1'b0;
      result_mixed <= 1'b0;
      wr_count     <= '0;
    end else begin
      result_mixed <= 1'b0;

      // Accepts only happen in UPDATE, which never clears the counter below
      if (accept && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (bus.infer_start) begin
            state <= INFER;
          end else if (bus.upd_begin) begin
            state    <= UPDATE;
            wr_count <= '0;
          end
        end

        INFER: begin
          if (bus.upd_begin) begin
            pend_begin <= 1'b1;
          end
          if (bus.infer_done) begin
            pend_begin <= 1'b0;
            if (pend_begin || bus.upd_begin) begin
              state    <= UPDATE;
              wr_count <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        UPDATE: begin
          if (bus.infer_start) begin
            state    <= UPD_INFER;
            mixed    <= 1'b1;
            pend_end <= 1'b0;
          end else if (bus.upd_end) begin
            state <= IDLE;
          end
        end

        UPD_INFER: begin
          mixed <= 1'b1;
          if (bus.upd_end) begin
            pend_end <= 1'b1;
          end
          if (bus.infer_done) begin
            result_mixed <= mixed;
            mixed        <= 1'b0;
            pend_end     <= 1'b0;
            state        <= (pend_end || bus.upd_end) ? IDLE : UPDATE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_ARB_CHECKSUM_EN
  // Wrapping sum of accepted write data, cleared whenever a batch opens
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_checksum <= '0;
    end else if (((state == IDLE) && !bus.infer_start && bus.upd_begin) ||
                 ((state == INFER) && bus.infer_done && (pend_begin || bus.upd_begin))) begin
      wr_checksum <= '0;
    end else if (accept) begin
      wr_checksum <= wr_checksum + 16'(bus.wr_data);
    end
  end
`else
  assign wr_checksum = '0;
`endif

  assign bus.wr_ready     = wr_ready;
  assign bus.ram_we       = ram_we;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_din      = ram_din;
  assign bus.result_mixed = result_mixed;
  assign bus.wr_count     = wr_count;
  assign bus.wr_checksum  = wr_checksum;
  assign bus.arb_state    = state;

endmodule

// File: doc/weight_update_arbiter.md
# weight_update_arbiter

Shares the per-lane `weight_ram` bank between two requesters. The inference read path is driven by `systolic_array` from `readout_start` to `result_valid`. The host write path loads new classifier weights at runtime. Inference always has priority. Host writes proceed only outside an inference pass, and the block flags any inference result computed over a partially updated weight set. It sits between `systolic_array`, the host/UART weight loader, and the `NUM_CLASSES` `weight_ram` instances of one read lane; one instance is placed per lane.

## Interface
Parameters:
- `NUM_CLASSES`, 4, number of class RAMs in the bank
- `NUM_CELLS`, 1024, cells per class RAM
- `WEIGHT_BITS`, 8, weight width
- `ADDR_BITS`, `$clog2(NUM_CELLS)`, cell address width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `infer_start` in 1: pulse, same as `readout_start` to `systolic_array`
- `infer_done` in 1: pulse, same as `result_valid` from `systolic_array`
- `rd_addr` in ADDR_BITS: systolic read address for this lane
- `upd_begin` in 1: pulse, host opens a weight-update batch
- `upd_end` in 1: pulse, host closes the batch
- `wr_valid` in 1: host write request
- `wr_ready` out 1: write accepted this cycle when `wr_valid && wr_ready`
- `wr_class` in `$clog2(NUM_CLASSES)`: target class RAM
- `wr_addr` in ADDR_BITS: target cell
- `wr_data` in WEIGHT_BITS: new weight
- `ram_we` out NUM_CLASSES: one-hot write enable to the class RAMs
- `ram_addr` out ADDR_BITS: shared RAM address
- `ram_din` out WEIGHT_BITS: shared RAM write data
- `result_mixed` out 1: valid with `infer_done`; the pass overlapped an open batch
- `wr_count` out 16: writes accepted in the current or last batch
- `wr_checksum` out 16: see Configuration
- `arb_state` out 2: current state, for debug

## Operation
- States and encodings: IDLE=0, INFER=1, UPDATE=2, UPD_INFER=3.
- IDLE:
  - `infer_start` → INFER.
  - Else `upd_begin` → UPDATE; this clears `wr_count` and `wr_checksum`.
- INFER: `infer_done` → IDLE. `upd_begin` received here is latched as pending and taken on the exit cycle, so the next state is UPDATE.
- UPDATE:
  - `infer_start` → UPD_INFER.
  - Else `upd_end` → IDLE.
- UPD_INFER:
  - `infer_done` → UPDATE.
  - An `upd_end` received here is latched; the exit then goes to IDLE.
  - Sets the internal mixed flag.
- `wr_ready = (state==UPDATE) && !infer_start`. Writes are refused in IDLE, INFER and UPD_INFER.
- Accepted write, combinational in the same cycle:
  - `ram_we[wr_class]=1`, `ram_addr=wr_addr`, `ram_din=wr_data`.
  - `wr_count` increments, saturating at 0xFFFF.
- No accepted write: `ram_we=0`, `ram_addr=rd_addr`, `ram_din=0`.
- `result_mixed` is registered and asserted for exactly the cycle after `infer_done` when the completing pass ran in UPD_INFER. Otherwise it is 0.
- Simultaneous-event priority:
  - `infer_start` beats `upd_begin`, `upd_end` and `wr_valid`.
  - `upd_begin` in UPDATE or UPD_INFER is ignored.
  - `upd_end` outside UPDATE or UPD_INFER is ignored.
- A `wr_class` of `NUM_CLASSES` or more is accepted but drives no `ram_we` bit, and is still counted.
- Reset mid-batch: return to IDLE and clear all pending flags. RAM contents are untouched.

## Timing
- Values after reset:
  - `arb_state`=0
  - `wr_ready`=0
  - `ram_we`=0
  - `result_mixed`=0
  - `wr_count`=0
  - `wr_checksum`=0
- Address/data/write-enable mux is zero latency (combinational), so `systolic_array` read timing is unchanged.
- State register updates on the clock edge after the triggering pulse; `wr_ready` follows the registered state.
- `result_mixed` has 1-cycle latency from `infer_done`.
- `wr_count` and `wr_checksum` update on the clock edge after the accepting cycle.

## Configuration
- `WEIGHT_ARB_CHECKSUM_EN` defined:
  - `wr_checksum` = 16-bit wrapping sum of the zero-extended `wr_data` over all accepted writes since the last `upd_begin`.
  - Host compares it against the expected value after `upd_end`.
- Not defined: `wr_checksum` is tied to 0 and no adder is built.

## Test plan
- Reset, then `upd_begin`, then 3 writes (class 2, addr 5/6/7, data 0x10/0x20/0x30), then `upd_end`:
  - `ram_we`=4'b0100 on each write cycle.
  - `wr_count`=3.
  - `wr_checksum`=0x0060 (with macro).
  - Back in IDLE.
- `infer_start` in IDLE with `wr_valid` held high: `wr_ready` stays 0 until after `infer_done`; `ram_addr` tracks `rd_addr` throughout.
- `infer_start` in the same cycle as an accepted-eligible write in UPDATE:
  - Write not accepted; `ram_we`=0.
  - State goes to 3.
  - After `infer_done`, state returns to 2 and `result_mixed`=1 for one cycle.
- `upd_begin` during INFER: state 1→2 on the `infer_done` cycle and `wr_count` cleared; `result_mixed`=0.
- `upd_end` during UPD_INFER: state 3→0 on `infer_done`; `result_mixed`=1.
- `rst` asserted in UPDATE after 2 writes: next cycle state=0, `wr_count`=0, `wr_ready`=0.
